playfield_scanner: RTL and testbench
====================================

PLAYFIELD_SCANNER -- requirements
Module: playfield_scanner

Interface
REQ-001 The module SHALL be parameterless; geometry SHALL come from package constants: PLAY_X0=240 (first play-area column, pixels), PLAY_Y0=80 (first play-area line), CELL_PX=16 (cell edge, pixels), COLS=10 (cells per row), ROWS=20 (cell rows), HBLANK_X=640 (first blanking column).
REQ-002 Clk  in  1  system clock; all state updates on rising edge.
REQ-003 Reset_n  in  1  reset, synchronous, active-low.
REQ-004 pixel_en  in  1  one-Clk pulse per pixel; DrawX/DrawY advance only on it.
REQ-005 DrawX, DrawY  in  10 each  current raster position from the VGA controller.
REQ-006 board_rd_en  out  1  board RAM read strobe.
REQ-007 board_rd_addr  out  8  cell address = row*COLS+col, range 0..199.
REQ-008 board_rd_data  in  block_color (3)  cell contents, valid exactly one Clk after board_rd_en.
REQ-009 piece_valid  in  1  active falling piece present.
REQ-010 piece_col[4]  in  4 each; piece_row[4]  in  5 each  cell coordinates of the four piece squares.
REQ-011 piece_color  in  block_color  color of the falling piece.
REQ-012 play_area  out  1  registered: current pixel lies inside the playfield.
REQ-013 block_type  out  block_color  registered: color class of the current cell.
REQ-014 busy  out  1  high while a row prefetch is in progress.

Function
REQ-015 Play area SHALL be PLAY_X0<=DrawX<PLAY_X0+160 and PLAY_Y0<=DrawY<PLAY_Y0+320; cell col=(DrawX-PLAY_X0)>>4 and row=(DrawY-PLAY_Y0)>>4, computed in 10-bit unsigned arithmetic and truncated.
REQ-016 play_area and block_type SHALL be registered every Clk from the current DrawX/DrawY, giving exactly 1-Clk latency.
REQ-017 A 10-entry line buffer SHALL hold the cell row currently displayed; block_type comes from its entry [col].
REQ-018 A prefetch trigger SHALL fire on a Clk with pixel_en=1, DrawX==HBLANK_X and DrawY==PLAY_Y0-1+16k for k=0..19 (DrawY 79,95,...,383); no trigger at DrawY 399 or above.
REQ-019 FSM states: IDLE, FETCH, DRAIN; IDLE->FETCH on trigger; FETCH issues 10 consecutive reads (one per Clk, col 0..9, addr=(k*10)+col); FETCH->DRAIN after col 9; DRAIN->IDLE after capturing the final read.
REQ-020 Each board_rd_data SHALL be written into line buffer entry [col] one Clk after its read; a full prefetch SHALL take 11 Clks from trigger to IDLE.
REQ-021 busy SHALL be high in FETCH and DRAIN, low in IDLE.
REQ-022 A trigger arriving while busy SHALL be ignored.
REQ-023 When piece_valid=1 and any (piece_col[i],piece_row[i]) equals the current (col,row) inside the play area, block_type SHALL be piece_color, overriding the line buffer.
REQ-024 Outside the play area, block_type SHALL be EMPTY and play_area 0.
REQ-025 board_rd_en SHALL be 0 in IDLE and DRAIN.

Reset
REQ-026 While Reset_n=0 at a Clk edge: FSM->IDLE, play_area=0, block_type=EMPTY, busy=0, board_rd_en=0, board_rd_addr=0, all line buffer entries=EMPTY.
REQ-027 Reset during FETCH/DRAIN SHALL abort the prefetch; no partial writes occur after the reset edge.

Structure
REQ-028 Geometry constants and a piece-coordinate typedef SHALL live in package types alongside block_color.
REQ-029 The line buffer SHALL be a sub-module playfield_line_buffer (10x3-bit, one write port, one async read port, synchronous clear).

Verification
REQ-030 Board row 0 = {CYAN,BLUE,...}; trigger at DrawY=79, DrawX=640 -> 10 reads to addr 0..9, busy high exactly 11 Clks, row-0 pixels show CYAN at DrawX=240..255.
REQ-031 DrawX=239/400, DrawY=80 -> play_area=0, block_type=EMPTY; DrawX=240, DrawY=399 -> play_area=1.
REQ-032 piece_valid=1, piece cell (3,0), piece_color=RED over board cell YELLOW -> DrawX=288, DrawY=80 yields RED 1 Clk later.
REQ-033 Trigger at DrawY=383 fetches addr 190..199; DrawY=399, DrawX=640 -> no board_rd_en.
REQ-034 Reset_n low at 5th FETCH Clk -> busy=0 next Clk, line buffer all EMPTY, no further reads.
REQ-035 Second trigger pulse injected while busy -> ignored, exactly 10 reads total.

Source files
------------

// File: rtl/playfield_scanner_pkg.sv
// Shared types and playfield geometry for the playfield scanner.
package types;

    // Cell / pixel color classes stored in the board RAM and line buffer
    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        CYAN   = 3'd1,
        BLUE   = 3'd2,
        ORANGE = 3'd3,
        YELLOW = 3'd4,
        GREEN  = 3'd5,
        PURPLE = 3'd6,
        RED    = 3'd7
    } block_color;

    // Cell coordinate of one square of the falling piece
    typedef struct packed {
        logic [3:0] col;
        logic [4:0] row;
    } piece_coord_t;

    // Prefetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    // Geometry (all pixel quantities in the 10-bit raster domain)
    localparam int         COLS       = 10;
    localparam int         ROWS       = 20;
    localparam int         CELL_SHIFT = 4;
    localparam logic [9:0] PLAY_X0    = 10'd240;
    localparam logic [9:0] PLAY_Y0    = 10'd80;
    localparam logic [9:0] CELL_PX    = 10'd16;
    localparam logic [9:0] HBLANK_X   = 10'd640;

    // Derived bounds: first column / line past the playfield
    localparam logic [9:0] PLAY_X1    = PLAY_X0 + 10'(COLS) * CELL_PX;
    localparam logic [9:0] PLAY_Y1    = PLAY_Y0 + 10'(ROWS) * CELL_PX;
    // Line following the last trigger line (first line of the last row)
    localparam logic [9:0] LAST_TRIG_NY = PLAY_Y1 - CELL_PX;
    localparam logic [3:0] LAST_COL   = 4'(COLS - 1);

    // Board RAM address of column 0 of a cell row (row * 10)
    function automatic logic [7:0] row_base_addr(input logic [4:0] row);
        logic [7:0] r8;
        r8 = {3'b000, row};
        return (r8 << 3) + (r8 << 1);
    endfunction

endpackage

// File: rtl/playfield_scanner_line_buffer.sv
// Ten-entry cell-row buffer: one write port, combinational read,
// synchronous clear that wipes every entry to EMPTY.
module playfield_line_buffer
    import types::*;
(
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_addr,
    input  block_color i_wr_data,
    input  logic [3:0] i_rd_addr,
    output block_color o_rd_data
);

    block_color w_cells [COLS];

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_entry
            block_color r_cell;

            // Per-entry storage: clear wins over a coincident write
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    r_cell <= EMPTY;
                end else if (i_wr_en && (i_wr_addr == 4'(gi))) begin
                    r_cell <= i_wr_data;
                end
            end

            assign w_cells[gi] = r_cell;
        end
    endgenerate

    // Read port; indices past the last column read as EMPTY
    always_comb begin
        o_rd_data = EMPTY;
        if (i_rd_addr <= LAST_COL) begin
            o_rd_data = w_cells[i_rd_addr];
        end
    end

endmodule

// File: rtl/playfield_scanner.sv
// Playfield scanner: prefetches one board row per cell row during
// horizontal blanking into a line buffer and classifies each raster
// pixel (inside/outside playfield, cell color with piece overlay).
module playfield_scanner
    import types::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       pixel_en,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       board_rd_en,
    output logic [7:0] board_rd_addr,
    input  block_color board_rd_data,
    input  logic       piece_valid,
    input  logic [3:0] piece_col [4],
    input  logic [4:0] piece_row [4],
    input  block_color piece_color,
    output logic       play_area,
    output block_color block_type,
    output logic       busy
);

    // ---------------- raster decode ----------------
    logic [9:0]   w_dx;
    logic [9:0]   w_dy;
    logic         w_in_area;
    piece_coord_t w_cur;
    logic [3:0]   w_hit;
    block_color   w_lb_data;
    block_color   w_cell_type;

    assign w_dx      = DrawX - PLAY_X0;
    assign w_dy      = DrawY - PLAY_Y0;
    assign w_in_area = (DrawX >= PLAY_X0) && (DrawX < PLAY_X1) &&
                       (DrawY >= PLAY_Y0) && (DrawY < PLAY_Y1);
    assign w_cur.col = 4'(w_dx >> CELL_SHIFT);
    assign w_cur.row = 5'(w_dy >> CELL_SHIFT);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_piece
            piece_coord_t w_sq;
            assign w_sq.col   = piece_col[gi];
            assign w_sq.row   = piece_row[gi];
            assign w_hit[gi]  = (w_sq == w_cur);
        end
    endgenerate

    // Cell color for the current pixel: piece overlays the buffered row
    always_comb begin
        w_cell_type = EMPTY;
        if (w_in_area) begin
            if (piece_valid && (|w_hit)) begin
                w_cell_type = piece_color;
            end else begin
                w_cell_type = w_lb_data;
            end
        end
    end

    // Pixel classification registered every clock (one cycle latency)
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            play_area  <= 1'b0;
            block_type <= EMPTY;
        end else begin
            play_area  <= w_in_area;
            block_type <= w_cell_type;
        end
    end

    // ---------------- prefetch trigger ----------------
    // Fires on the last line of each cell row (and the line just above
    // the playfield), so the buffer holds row k for lines of row k.
    logic [9:0] w_next_y;
    logic [9:0] w_ny_off;
    logic [4:0] w_trig_row;
    logic       w_trig;

    assign w_next_y   = DrawY + 10'd1;
    assign w_ny_off   = w_next_y - PLAY_Y0;
    assign w_trig_row = 5'(w_ny_off >> CELL_SHIFT);
    assign w_trig     = pixel_en && (DrawX == HBLANK_X) &&
                        (w_next_y[3:0] == 4'd0) &&
                        (w_next_y >= PLAY_Y0) && (w_next_y <= LAST_TRIG_NY);

    // ---------------- prefetch sequencer ----------------
    scan_state_t r_state;
    logic [3:0]  r_col;
    logic        r_cap_en;
    logic [3:0]  r_cap_col;

    // Row prefetch FSM with registered read strobe/address and the
    // one-cycle-delayed capture controls for the returning data
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state       <= ST_IDLE;
            r_col         <= 4'd0;
            r_cap_en      <= 1'b0;
            r_cap_col     <= 4'd0;
            board_rd_en   <= 1'b0;
            board_rd_addr <= 8'd0;
            busy          <= 1'b0;
        end else begin
            // Data for the read issued this cycle arrives next cycle
            r_cap_en  <= board_rd_en;
            r_cap_col <= r_col;
            case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        r_state       <= ST_FETCH;
                        r_col         <= 4'd0;
                        board_rd_en   <= 1'b1;
                        board_rd_addr <= row_base_addr(w_trig_row);
                        busy          <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (r_col == LAST_COL) begin
                        r_state     <= ST_DRAIN;
                        board_rd_en <= 1'b0;
                    end else begin
                        r_col         <= r_col + 4'd1;
                        board_rd_addr <= board_rd_addr + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    // Final column is captured on this edge
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    board_rd_en <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- line buffer ----------------
    logic w_lb_clr;
    assign w_lb_clr = !Reset_n;

    playfield_line_buffer u_line_buffer (
        .i_clk     (Clk),
        .i_clr     (w_lb_clr),
        .i_wr_en   (r_cap_en),
        .i_wr_addr (r_cap_col),
        .i_wr_data (board_rd_data),
        .i_rd_addr (w_cur.col),
        .o_rd_data (w_lb_data)
    );

endmodule

// File: tb/tb_playfield_scanner.sv
// Directed bench for playfield_scanner with a board RAM model, an
// expected-read queue and an expected-pixel queue.
module tb_playfield_scanner;
    import types::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       pixel_en;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       board_rd_en;
    logic [7:0] board_rd_addr;
    block_color board_rd_data;
    logic       piece_valid;
    logic [3:0] piece_col [4];
    logic [4:0] piece_row [4];
    block_color piece_color;
    logic       play_area;
    block_color block_type;
    logic       busy;

    always #5 Clk = ~Clk;

    playfield_scanner dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .pixel_en      (pixel_en),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .board_rd_en   (board_rd_en),
        .board_rd_addr (board_rd_addr),
        .board_rd_data (board_rd_data),
        .piece_valid   (piece_valid),
        .piece_col     (piece_col),
        .piece_row     (piece_row),
        .piece_color   (piece_color),
        .play_area     (play_area),
        .block_type    (block_type),
        .busy          (busy)
    );

    // Board RAM model: registered read
    block_color mem [200];
    always @(posedge Clk) begin
        if (board_rd_en) board_rd_data <= mem[board_rd_addr];
    end

    int total = 0;
    int bad   = 0;
    int reads_seen  = 0;
    int busy_cycles = 0;
    int exp_addr_q [$];

    typedef struct {
        int         x;
        int         y;
        logic       play;
        block_color btype;
    } pix_exp_t;
    pix_exp_t pix_q [$];

    block_color lb_model [10];

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Read monitor: every strobe must match the next expected address
    always @(negedge Clk) begin
        if (busy === 1'b1) busy_cycles++;
        if (board_rd_en === 1'b1) begin
            reads_seen++;
            if (exp_addr_q.size() == 0)
                check("unexpected_read", int'(board_rd_addr), -1);
            else
                check("rd_addr", int'(board_rd_addr), exp_addr_q.pop_front());
        end
    end

    function automatic logic model_play(input int x, input int y);
        return (x >= 240) && (x < 400) && (y >= 80) && (y < 400);
    endfunction

    function automatic block_color model_type(input int x, input int y);
        int c, r;
        if (!model_play(x, y)) return EMPTY;
        c = (x - 240) / 16;
        r = (y - 80) / 16;
        if (piece_valid)
            for (int i = 0; i < 4; i++)
                if (int'(piece_col[i]) == c && int'(piece_row[i]) == r) return piece_color;
        return lb_model[c];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Drive one raster position, check its classification one clock later
    task automatic pix(input int x, input int y);
        pix_exp_t e, g;
        DrawX = 10'(x);
        DrawY = 10'(y);
        e.x = x; e.y = y; e.play = model_play(x, y); e.btype = model_type(x, y);
        pix_q.push_back(e);
        step(1);
        g = pix_q.pop_front();
        $display("pixel x=%0d y=%0d play=%0d type=%0d", g.x, g.y, play_area, block_type);
        check($sformatf("play_area(%0d,%0d)", g.x, g.y), int'(play_area), int'(g.play));
        check($sformatf("block_type(%0d,%0d)", g.x, g.y), int'(block_type), int'(g.btype));
    endtask

    task automatic trigger(input int y);
        DrawX = 10'd640;
        DrawY = 10'(y);
        pixel_en = 1'b1;
        step(1);
        pixel_en = 1'b0;
        DrawX = 10'd0;
        DrawY = 10'd0;
    endtask

    // Full prefetch of cell row k with read/busy accounting
    task automatic fetch_row(input int k);
        reads_seen = 0;
        busy_cycles = 0;
        for (int c = 0; c < 10; c++) exp_addr_q.push_back(k * 10 + c);
        trigger(79 + 16 * k);
        check("busy_after_trigger", int'(busy), 1);
        step(15);
        $display("fetch row=%0d reads=%0d busy_cycles=%0d", k, reads_seen, busy_cycles);
        check("fetch_reads", reads_seen, 10);
        check("fetch_busy_cycles", busy_cycles, 11);
        check("fetch_queue_left", exp_addr_q.size(), 0);
        check("busy_idle", int'(busy), 0);
        for (int c = 0; c < 10; c++) lb_model[c] = mem[k * 10 + c];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 200; i++) mem[i] = block_color'(3'((i % 7) + 1));
        for (int c = 0; c < 10; c++) lb_model[c] = EMPTY;
        Reset_n = 1'b0;
        pixel_en = 1'b0;
        DrawX = 10'd0;
        DrawY = 10'd0;
        board_rd_data = EMPTY;
        piece_valid = 1'b0;
        piece_col = '{4'd3, 4'd9, 4'd0, 4'd1};
        piece_row = '{5'd0, 5'd19, 5'd5, 5'd5};
        piece_color = RED;

        // Reset state
        step(3);
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(board_rd_en), 0);
        check("rst_rd_addr", int'(board_rd_addr), 0);
        check("rst_play_area", int'(play_area), 0);
        check("rst_block_type", int'(block_type), int'(EMPTY));
        Reset_n = 1'b1;
        step(2);

        // Row 0 prefetch and display
        fetch_row(0);
        for (int x = 240; x < 256; x++) pix(x, 80);
        for (int c = 0; c < 10; c++) pix(240 + 16 * c + 7, 90);

        // Playfield boundaries
        pix(239, 80);
        pix(400, 80);
        pix(399, 80);
        pix(240, 399);
        pix(240, 400);
        pix(240, 79);

        // Piece overlay over a YELLOW board cell
        piece_valid = 1'b1;
        pix(288, 80);
        pix(256, 80);
        pix(304, 95);
        piece_valid = 1'b0;
        pix(288, 80);

        // Last row prefetch, then the out-of-range trigger line
        fetch_row(19);
        for (int c = 0; c < 10; c++) pix(240 + 16 * c, 384);
        piece_valid = 1'b1;
        pix(384, 384);
        piece_valid = 1'b0;
        reads_seen = 0;
        trigger(399);
        step(12);
        check("no_reads_at_399", reads_seen, 0);
        check("busy_at_399", int'(busy), 0);

        // Trigger position without pixel_en does nothing
        DrawX = 10'd640;
        DrawY = 10'd79;
        step(1);
        DrawX = 10'd0;
        DrawY = 10'd0;
        step(12);
        check("no_reads_without_pixel_en", reads_seen, 0);

        // Reset in the fifth FETCH clock aborts the prefetch
        reads_seen = 0;
        for (int a = 10; a < 15; a++) exp_addr_q.push_back(a);
        trigger(95);
        step(4);
        Reset_n = 1'b0;
        step(1);
        check("abort_busy", int'(busy), 0);
        check("abort_rd_en", int'(board_rd_en), 0);
        Reset_n = 1'b1;
        for (int c = 0; c < 10; c++) lb_model[c] = EMPTY;
        step(12);
        check("abort_reads", reads_seen, 5);
        check("abort_queue_left", exp_addr_q.size(), 0);
        for (int c = 0; c < 10; c++) pix(240 + 16 * c + 2, 100);

        // Second trigger while busy is ignored
        reads_seen = 0;
        busy_cycles = 0;
        for (int c = 0; c < 10; c++) exp_addr_q.push_back(c);
        trigger(79);
        step(3);
        DrawX = 10'd640;
        DrawY = 10'd79;
        pixel_en = 1'b1;
        step(1);
        pixel_en = 1'b0;
        DrawX = 10'd0;
        DrawY = 10'd0;
        step(15);
        check("retrig_reads", reads_seen, 10);
        check("retrig_busy_cycles", busy_cycles, 11);
        check("retrig_queue_left", exp_addr_q.size(), 0);
        for (int c = 0; c < 10; c++) lb_model[c] = mem[c];
        for (int c = 0; c < 10; c++) pix(240 + 16 * c + 9, 81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
